// File: rtl/giga_mc_ctrl.sv
// Multicycle sequencing controller for the Giga mini-MIPS core: steps the shared datapath
// through fetch/decode/execute/memory/writeback, handshakes with memory and counts retirements.
module giga_mc_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [5:0]       opcode_i,
    input  logic [5:0]       funct_i,
    input  logic             zero_i,
    input  logic             mem_ready_i,
    output logic             pc_we_o,
    output logic [1:0]       pc_src_o,
    output logic             ir_we_o,
    output logic             mdr_we_o,
    output logic             iord_o,
    output logic             mem_req_o,
    output logic             mem_we_o,
    output logic             alu_src_a_o,
    output logic [1:0]       alu_src_b_o,
    output logic [1:0]       alu_op_o,
    output logic             reg_dst_o,
    output logic             mem_to_reg_o,
    output logic             reg_we_o,
    output logic             freg_we_o,
    output logic             busy_o,
    output logic             halted_o,
    output logic             err_o,
    output logic [1:0]       err_code_o,
    output logic [CNT_W-1:0] retired_o
);

    localparam logic [5:0] OpR    = 6'b000000;
    localparam logic [5:0] OpCop1 = 6'b010001;
    localparam logic [5:0] OpAddi = 6'b001000;
    localparam logic [5:0] OpLw   = 6'b100011;
    localparam logic [5:0] OpSw   = 6'b101011;
    localparam logic [5:0] OpBeq  = 6'b000100;
    localparam logic [5:0] OpBne  = 6'b000101;
    localparam logic [5:0] OpJ    = 6'b000010;
    localparam logic [5:0] OpHalt = 6'b111111;

    localparam logic [1:0] ErrIllegal = 2'b01;
    localparam logic [1:0] ErrTimeout = 2'b10;

    localparam int unsigned    TmoW    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [TmoW-1:0] TmoLast = TmoW'(MEM_TIMEOUT - 1);

    typedef enum logic [3:0] {
        StIdle, StFetch, StDecode, StExec, StMemRd, StMemWr,
        StWb, StBranch, StJump, StHalt, StErr
    } state_e;

    state_e           state_q, state_d;
    logic [5:0]       op_q, op_d;
    logic [5:0]       funct_q, funct_d;
    logic [TmoW-1:0]  tmo_q, tmo_d;
    logic [1:0]       err_code_q, err_code_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             retire;
    logic             mem_wait;
    logic             tmo_hit;

    // funct_q is held for the datapath's view of the decoded instruction; ALU control
    // decodes funct directly, so nothing in this block consumes it.
    logic unused_funct;
    assign unused_funct = ^funct_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            op_q       <= '0;
            funct_q    <= '0;
            tmo_q      <= '0;
            err_code_q <= '0;
            retired_q  <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            funct_q    <= funct_d;
            tmo_q      <= tmo_d;
            err_code_q <= err_code_d;
            retired_q  <= retired_d;
        end
    end

    // The counter is zero whenever a wait is not in progress, so every memory state starts clean.
    assign mem_wait = (state_q == StFetch || state_q == StMemRd || state_q == StMemWr)
                      && !mem_ready_i;
    assign tmo_hit  = mem_wait && (tmo_q == TmoLast);
    assign tmo_d    = (mem_wait && !tmo_hit) ? tmo_q + TmoW'(1) : '0;

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        funct_d    = funct_q;
        err_code_d = err_code_q;
        retire     = 1'b0;
        case (state_q)
            StIdle: if (start_i) state_d = StFetch;
            StFetch: begin
                if (mem_ready_i) begin
                    state_d = StDecode;
                end else if (tmo_hit) begin
                    state_d    = StErr;
                    err_code_d = ErrTimeout;
                end
            end
            StDecode: begin
                op_d    = opcode_i;
                funct_d = funct_i;
                case (opcode_i)
                    OpR, OpCop1, OpAddi, OpLw, OpSw: state_d = StExec;
                    OpBeq, OpBne:                    state_d = StBranch;
                    OpJ:                             state_d = StJump;
                    OpHalt:                          state_d = StHalt;
                    default: begin
                        state_d    = StErr;
                        err_code_d = ErrIllegal;
                    end
                endcase
            end
            StExec: begin
                if (op_q == OpLw)      state_d = StMemRd;
                else if (op_q == OpSw) state_d = StMemWr;
                else                   state_d = StWb;
            end
            StMemRd: begin
                if (mem_ready_i) begin
                    state_d = StWb;
                end else if (tmo_hit) begin
                    state_d    = StErr;
                    err_code_d = ErrTimeout;
                end
            end
            StMemWr: begin
                if (mem_ready_i) begin
                    state_d = StFetch;
                    retire  = 1'b1;
                end else if (tmo_hit) begin
                    state_d    = StErr;
                    err_code_d = ErrTimeout;
                end
            end
            StWb, StBranch, StJump: begin
                state_d = StFetch;
                retire  = 1'b1;
            end
            StHalt:  state_d = StHalt;
            StErr:   state_d = StErr;
            default: state_d = StErr;
        endcase
    end

    assign retired_d = retire ? retired_q + CNT_W'(1) : retired_q;

    always_comb begin
        pc_we_o      = 1'b0;
        pc_src_o     = 2'b00;
        ir_we_o      = 1'b0;
        mdr_we_o     = 1'b0;
        iord_o       = 1'b0;
        mem_req_o    = 1'b0;
        mem_we_o     = 1'b0;
        alu_src_a_o  = 1'b0;
        alu_src_b_o  = 2'b00;
        alu_op_o     = 2'b00;
        reg_dst_o    = 1'b0;
        mem_to_reg_o = 1'b0;
        reg_we_o     = 1'b0;
        freg_we_o    = 1'b0;
        case (state_q)
            StFetch: begin
                mem_req_o   = 1'b1;
                alu_src_b_o = 2'b01;
                ir_we_o     = mem_ready_i;
                pc_we_o     = mem_ready_i;
            end
            StDecode: alu_src_b_o = 2'b11;
            StExec: begin
                alu_src_a_o = 1'b1;
                if (op_q == OpR || op_q == OpCop1) begin
                    alu_src_b_o = 2'b00;
                    alu_op_o    = 2'b10;
                end else begin
                    alu_src_b_o = 2'b10;
                end
            end
            StMemRd: begin
                mem_req_o = 1'b1;
                iord_o    = 1'b1;
                mdr_we_o  = mem_ready_i;
            end
            StMemWr: begin
                mem_req_o = 1'b1;
                mem_we_o  = 1'b1;
                iord_o    = 1'b1;
            end
            StWb: begin
                case (op_q)
                    OpR: begin
                        reg_we_o  = 1'b1;
                        reg_dst_o = 1'b1;
                    end
                    OpAddi: reg_we_o = 1'b1;
                    OpLw: begin
                        reg_we_o     = 1'b1;
                        mem_to_reg_o = 1'b1;
                    end
                    OpCop1:  freg_we_o = 1'b1;
                    default: reg_we_o  = 1'b0;
                endcase
            end
            StBranch: begin
                alu_src_a_o = 1'b1;
                alu_op_o    = 2'b01;
                pc_src_o    = 2'b01;
                pc_we_o     = (op_q == OpBne) ? ~zero_i : zero_i;
            end
            StJump: begin
                pc_we_o  = 1'b1;
                pc_src_o = 2'b10;
            end
            default: pc_we_o = 1'b0;
        endcase
    end

    assign busy_o     = !(state_q == StIdle || state_q == StHalt || state_q == StErr);
    assign halted_o   = (state_q == StHalt);
    assign err_o      = (state_q == StErr);
    assign err_code_o = err_code_q;
    assign retired_o  = retired_q;

endmodule

// File: doc/giga_mc_ctrl.md
Name: giga_mc_ctrl

Overview:
- Multicycle sequencing controller for the Giga mini-MIPS core.
- Replaces the single-cycle opcode decoder with a state machine that steps the shared datapath (PC, IR, register files, ALU, unified memory port) through fetch, decode, execute, memory and writeback.
- Handshakes with a variable-latency memory and counts retired instructions.
- Traps illegal opcodes and memory timeouts.

Parameters:
- MEM_TIMEOUT, 16, max cycles mem_req may wait for mem_ready before the error trap.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  leaves IDLE and begins fetching.
- opcode  in  6  IR[31:26] from the datapath instruction register.
- funct  in  6  IR[5:0].
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completion; may be high in the same cycle as mem_req.
- pc_we  out  1  PC load strobe.
- pc_src  out  2  PC source: 00 = ALU (PC+4), 01 = branch target, 10 = jump target.
- ir_we  out  1  IR load strobe.
- mdr_we  out  1  memory data register load strobe.
- iord  out  1  memory address select: 0 = PC, 1 = ALU output register.
- mem_req  out  1  memory request.
- mem_we  out  1  memory write qualifier, valid with mem_req.
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = rs.
- alu_src_b  out  2  ALU B select: 00 = rt, 01 = const 4, 10 = sign-extended immediate, 11 = immediate<<2.
- alu_op  out  2  to ALU control: 00 = add, 01 = sub, 10 = funct-decoded.
- reg_dst  out  1  register destination: 1 = rd, 0 = rt.
- mem_to_reg  out  1  writeback source: 1 = MDR, 0 = ALU output.
- reg_we  out  1  integer register file write strobe.
- freg_we  out  1  float register file write strobe.
- busy  out  1  high in every state except IDLE, HALT and ERR.
- halted  out  1  high in HALT.
- err  out  1  high in ERR.
- err_code  out  2  01 = illegal opcode, 10 = memory timeout.
- retired  out  CNT_W  retired-instruction count.

Behaviour:
- States: IDLE, FETCH, DECODE, EXEC, MEM_RD, MEM_WR, WB, BRANCH, JUMP, HALT, ERR.
- Outputs are decoded from the state register and the opcode latched in DECODE (op_q, funct_q). All strobes are 0 unless listed for a state.
- Reset (rst=0, asynchronous): state=IDLE, op_q=0, timeout counter=0, retired=0, err_code=00, all outputs 0. Reset asserted mid-instruction aborts it immediately with no further strobes.
- IDLE: start=1 -> FETCH.
- FETCH: mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00. In the cycle mem_ready=1: ir_we=1, pc_we=1, pc_src=00, next state DECODE.
- DECODE: latch op_q/funct_q; alu_src_a=0, alu_src_b=11, alu_op=00 (branch target precompute). Next state by opcode:
  - 000000 (R) -> EXEC
  - 010001 (COP1) -> EXEC
  - 001000 (addi) -> EXEC
  - 100011 (lw) -> EXEC
  - 101011 (sw) -> EXEC
  - 000100 (beq) -> BRANCH
  - 000101 (bne) -> BRANCH
  - 000010 (j) -> JUMP
  - 111111 (halt) -> HALT
  - any other opcode -> ERR with err_code=01.
- EXEC: alu_src_a=1.
  - R/COP1: alu_src_b=00, alu_op=10.
  - addi/lw/sw: alu_src_b=10, alu_op=00.
  - Next state: lw -> MEM_RD, sw -> MEM_WR, others -> WB.
- MEM_RD: mem_req=1, iord=1. On mem_ready: mdr_we=1, next state WB.
- MEM_WR: mem_req=1, mem_we=1, iord=1. On mem_ready: retire, next state FETCH.
- WB:
  - R: reg_we=1, reg_dst=1.
  - addi: reg_we=1, reg_dst=0.
  - lw: reg_we=1, reg_dst=0, mem_to_reg=1.
  - COP1: freg_we=1 (reg_we=0).
  - Retire; next state FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01. pc_we = zero for beq, ~zero for bne. Retire; next state FETCH.
- JUMP: pc_we=1, pc_src=10. Retire; next state FETCH.
- Latency with zero-wait memory: R/addi/COP1 = 4 cycles, lw = 5, sw = 4, beq/bne/j = 3.
- Each memory wait cycle extends FETCH, MEM_RD or MEM_WR by exactly one cycle.
- Timeout counter:
  - Clears on entry to each memory state and increments every cycle mem_ready=0 in that state.
  - Reaching MEM_TIMEOUT -> ERR with err_code=10 and no strobes.
  - mem_ready=1 in the same cycle as the limit is reached wins (normal completion).
- retired increments by 1 on each retire and wraps from 2^CNT_W-1 to 0.
- HALT and ERR are absorbing; only reset exits them. start is ignored outside IDLE.
- mem_ready outside memory states is ignored.

Test Plan:
- Reset, start=1, mem_ready=1 constant, opcode 000000 -> FETCH, DECODE, EXEC, WB in 4 cycles; reg_we=1 with reg_dst=1 only in WB; retired=1.
- lw (100011) with mem_ready low for 3 cycles in MEM_RD -> mdr_we pulses once in the cycle mem_ready rises; reg_we/mem_to_reg=1 next cycle; total 8 cycles.
- beq with zero=1 vs zero=0, then bne with zero=0 -> pc_we=1, 0, 1 in BRANCH with pc_src=01; retired increments on each.
- Opcode 111011 -> ERR after DECODE with err_code=01, busy=0; opcode 111111 -> halted=1; further start ignored; rst=0 restores IDLE.
- mem_ready held 0 in FETCH with MEM_TIMEOUT=16 -> ERR with err_code=10 after 16 wait cycles; variant with mem_ready=1 on the 16th cycle -> DECODE.
- Assert rst=0 mid MEM_WR -> mem_req and mem_we drop asynchronously; retired unchanged at 0; CNT_W=4 run of 17 instructions -> retired=1.
